// File: rtl/llr_pkg.sv
// Shared constants and helpers for the LLR min / min-sum pipeline.
package llr_pkg;

    localparam int unsigned LLR_W = 8;

    localparam logic MODE_UMIN = 1'b0;
    localparam logic MODE_FSUM = 1'b1;

    // Magnitude of a sign-extended w-bit value, clamped so -2^(w-1) maps to 2^(w-1)-1.
    function automatic logic [31:0] sat_abs(input logic [31:0] x, input int unsigned w);
        logic [31:0] max_mag;
        logic [31:0] mag;
        max_mag = (32'd1 << (w - 1)) - 32'd1;
        mag     = x[31] ? (~x + 32'd1) : x;
        return (mag > max_mag) ? max_mag : mag;
    endfunction

endpackage

// File: rtl/llr_min_lane.sv
// One lane of the two-stage min / min-sum datapath; enables come from the top-level handshake.
module llr_min_lane
    import llr_pkg::*;
#(
    parameter int unsigned W = LLR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en1_i,
    input  logic         en2_i,
    input  logic         mode_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] res_o,
    output logic         sel_o
);

    logic [W-1:0] ma_d, ma_q;
    logic [W-1:0] mb_d, mb_q;
    logic         sgn_d, sgn_q;
    logic         mode_d, mode_q;
    logic [W-1:0] res_d, res_q;
    logic         sel_d, sel_q;

    logic [31:0]  a_ext, b_ext;
    logic         lt;
    logic [W-1:0] m;

    assign a_ext = 32'($signed(a_i));
    assign b_ext = 32'($signed(b_i));

    always_comb begin
        mode_d = mode_i;
        ma_d   = a_i;
        mb_d   = b_i;
        sgn_d  = 1'b0;
        if (mode_i == MODE_FSUM) begin
            ma_d  = W'(sat_abs(a_ext, W));
            mb_d  = W'(sat_abs(b_ext, W));
            sgn_d = a_i[W-1] ^ b_i[W-1];
        end
    end

    // Ties pick B, as the legacy comparator did.
    always_comb begin
        lt    = (ma_q < mb_q);
        m     = lt ? ma_q : mb_q;
        sel_d = !lt;
        res_d = ((mode_q == MODE_FSUM) && sgn_q) ? -m : m;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_q   <= '0;
            mb_q   <= '0;
            sgn_q  <= 1'b0;
            mode_q <= MODE_UMIN;
            res_q  <= '0;
            sel_q  <= 1'b0;
        end else begin
            if (en1_i) begin
                ma_q   <= ma_d;
                mb_q   <= mb_d;
                sgn_q  <= sgn_d;
                mode_q <= mode_d;
            end
            if (en2_i) begin
                res_q <= res_d;
                sel_q <= sel_d;
            end
        end
    end

    assign res_o = res_q;
    assign sel_o = sel_q;

endmodule

// File: rtl/llr_min_pipe.sv
// Two-stage, full-throughput LANES-wide unsigned-min / polar min-sum f unit with valid/ready.
module llr_min_pipe
    import llr_pkg::*;
#(
    parameter int unsigned W     = LLR_W,
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [LANES*W-1:0] in_a,
    input  logic [LANES*W-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_res,
    output logic [LANES-1:0]   out_sel
);

    logic s1_valid_d, s1_valid_q;
    logic s2_valid_d, s2_valid_q;
    logic en1, en2;

    // Ready ripples back combinationally; a full pipe still accepts when the output drains.
    assign en2      = !s2_valid_q || out_ready;
    assign en1      = !s1_valid_q || en2;
    assign in_ready = en1;

    always_comb begin
        s1_valid_d = en1 ? in_valid : s1_valid_q;
        s2_valid_d = en2 ? s1_valid_q : s2_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    assign out_valid = s2_valid_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        llr_min_lane #(
            .W(W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en1_i (en1),
            .en2_i (en2),
            .mode_i(in_mode),
            .a_i   (in_a[i*W +: W]),
            .b_i   (in_b[i*W +: W]),
            .res_o (out_res[i*W +: W]),
            .sel_o (out_sel[i])
        );
    end

endmodule

// File: tb/tb_llr_min_pipe.sv
// Scoreboarded bench for llr_min_pipe at W=8, LANES=4.
module tb_llr_min_pipe;

    localparam int unsigned W     = 8;
    localparam int unsigned LANES = 4;
    localparam int          MAXM  = (1 << (W - 1)) - 1;

    typedef struct packed {
        logic [LANES-1:0]   sel;
        logic [LANES*W-1:0] res;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               in_mode;
    logic [LANES*W-1:0] in_a;
    logic [LANES*W-1:0] in_b;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*W-1:0] out_res;
    logic [LANES-1:0]   out_sel;

    int   checks    = 0;
    int   errors    = 0;
    int   out_count = 0;
    exp_t sb[$];

    llr_min_pipe #(
        .W    (W),
        .LANES(LANES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res  (out_res),
        .out_sel  (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LANES*W-1:0] pack4(input int l0, input int l1, input int l2,
                                                 input int l3);
        return {W'(l3), W'(l2), W'(l1), W'(l0)};
    endfunction

    function automatic exp_t golden(input logic mode, input logic [LANES*W-1:0] a,
                                    input logic [LANES*W-1:0] b);
        exp_t e;
        int sa, sb_v, ma, mb, m, r;
        bit sgn, s;
        for (int i = 0; i < LANES; i++) begin
            if (mode) begin
                sa   = int'($signed(a[i*W +: W]));
                sb_v = int'($signed(b[i*W +: W]));
                ma   = (sa < 0) ? -sa : sa;
                mb   = (sb_v < 0) ? -sb_v : sb_v;
                if (ma > MAXM) ma = MAXM;
                if (mb > MAXM) mb = MAXM;
                sgn = (sa < 0) != (sb_v < 0);
            end else begin
                ma  = int'(a[i*W +: W]);
                mb  = int'(b[i*W +: W]);
                sgn = 1'b0;
            end
            s = !(ma < mb);
            m = s ? mb : ma;
            r = sgn ? -m : m;
            e.sel[i]       = s;
            e.res[i*W +: W] = W'(r);
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            3:       return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [LANES*W-1:0] rnd_vec();
        logic [LANES*W-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*W +: W] = rnd_op();
        return v;
    endfunction

    task automatic set_in(input logic v, input logic mode, input logic [LANES*W-1:0] a,
                          input logic [LANES*W-1:0] b);
        in_valid = v;
        in_mode  = mode;
        in_a     = a;
        in_b     = b;
    endtask

    // Sampled mid-cycle, where inputs and outputs are both settled for the next edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (in_valid && in_ready) sb.push_back(golden(in_mode, in_a, in_b));
                if (out_valid && out_ready) begin
                    checks++;
                    out_count++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: got res=%h sel=%b, required no output",
                                 out_res, out_sel);
                    end else begin
                        e = sb.pop_front();
                        if (out_res !== e.res || out_sel !== e.sel) begin
                            errors++;
                            $display("FAIL sb_data: got res=%h sel=%b, required res=%h sel=%b",
                                     out_res, out_sel, e.res, e.sel);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 1'b0, '0, '0);
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        checks++;
        if (out_res !== '0) begin
            errors++; $display("FAIL reset_out_res: got %h required 0", out_res);
        end
        checks++;
        if (out_sel !== '0) begin
            errors++; $display("FAIL reset_out_sel: got %b required 0", out_sel);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_umin();
        out_ready = 1'b1;
        set_in(1'b1, 1'b0, pack4(200, 5, 0, 255), pack4(17, 5, 1, 254));
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, '0, '0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL umin_early_valid: got %b required 0", out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL umin_latency: got %b required 1", out_valid);
        end
        checks++;
        if (out_res !== pack4(17, 5, 0, 254) || out_sel !== 4'b1011) begin
            errors++;
            $display("FAIL umin_result: got res=%h sel=%b required res=%h sel=1011",
                     out_res, out_sel, pack4(17, 5, 0, 254));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fsum();
        out_ready = 1'b1;
        set_in(1'b1, 1'b1, pack4(8'hEC, 8'h80, 8'h05, 8'h00), pack4(8'h07, 8'h80, 8'hFD, 8'h90));
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_res !== pack4(8'hF9, 8'h7F, 8'hFD, 8'h00)
            || out_sel !== 4'b0111) begin
            errors++;
            $display("FAIL fsum_result: got v=%b res=%h sel=%b required v=1 res=%h sel=0111",
                     out_valid, out_res, out_sel, pack4(8'hF9, 8'h7F, 8'hFD, 8'h00));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int bad_valid = 0;
        int bad_ready = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 10) set_in(1'b1, c[0], rnd_vec(), rnd_vec());
            else        set_in(1'b0, 1'b0, '0, '0);
            #1;
            if (out_valid !== (c >= 2)) bad_valid++;
            if (in_ready !== 1'b1) bad_ready++;
            @(posedge clk); #1;
        end
        set_in(1'b0, 1'b0, '0, '0);
        checks++;
        if (bad_valid != 0) begin
            errors++; $display("FAIL b2b_valid_pattern: got %0d bad cycles required 0", bad_valid);
        end
        checks++;
        if (bad_ready != 0) begin
            errors++; $display("FAIL b2b_in_ready: got %0d stalled cycles required 0", bad_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [LANES*W-1:0] ta[5];
        logic [LANES*W-1:0] tb[5];
        logic [LANES*W-1:0] held;
        int acc = 0;
        int outs0 = out_count;
        int hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            ta[i] = rnd_vec();
            tb[i] = rnd_vec();
        end
        held = '0;
        for (int c = 0; c < 40 && (out_count - outs0) < 5; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            if (acc < 5) set_in(1'b1, acc[0], ta[acc], tb[acc]);
            else         set_in(1'b0, 1'b0, '0, '0);
            #1;
            if (c == 2) begin
                checks++;
                if (in_ready !== 1'b0 || acc != 2) begin
                    errors++;
                    $display("FAIL bp_in_ready: got ready=%b after %0d accepted, required 0 after 2",
                             in_ready, acc);
                end
                held = out_res;
            end
            if (c >= 3 && c <= 5 && (out_res !== held || out_valid !== 1'b1)) hold_bad++;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
        end
        set_in(1'b0, 1'b0, '0, '0);
        out_ready = 1'b1;
        checks++;
        if (hold_bad != 0) begin
            errors++; $display("FAIL bp_hold: got %0d unstable cycles required 0", hold_bad);
        end
        checks++;
        if (out_count - outs0 != 5) begin
            errors++; $display("FAIL bp_drain: got %0d outputs required 5", out_count - outs0);
        end
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        out_ready = 1'b0;
        set_in(1'b1, 1'b1, rnd_vec(), rnd_vec());
        @(posedge clk); #1;
        set_in(1'b1, 1'b0, rnd_vec(), rnd_vec());
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, '0, '0);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_full: got v=%b ready=%b required v=1 ready=0",
                     out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_res !== '0 || out_sel !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: got v=%b res=%h sel=%b required all 0",
                     out_valid, out_res, out_sel);
        end
        sb.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_ready: got %b required 1", in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++; $display("FAIL rst_mid_stale: got %0d valid cycles required 0", stale);
        end
    endtask

    task automatic test_random();
        int acc = 0;
        int cyc = 0;
        while (acc < 2500 && cyc < 20000) begin
            set_in(($urandom_range(0, 9) < 7), 1'($urandom), rnd_vec(), rnd_vec());
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        set_in(1'b0, 1'b0, '0, '0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (acc != 2500) begin
            errors++; $display("FAIL rand_timeout: got %0d accepted required 2500", acc);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL rand_drain: got %0d pending required 0", sb.size());
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_umin();
        test_fsum();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
